icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter DATA_WIDTH, 32, instruction and memory word width in bits.
REQ-002 Parameter ADDRESS_WIDTH, 32, fetch address width in bits.
REQ-003 Parameter SETS, 16, number of direct-mapped lines; a power of two, at least 2.
REQ-004 The block SHALL have one clock, with a synchronous, active-high reset.
REQ-005 CLK  input  1  rising-edge clock.
REQ-006 RST  input  1  synchronous reset, active high.
REQ-007 A  input  ADDRESS_WIDTH  fetch byte address (PCF).
REQ-008 RD  output  DATA_WIDTH  instruction for A; valid only when StallI=0.
REQ-009 StallI  output  1  high when RD is not valid this cycle; ORed into StallF/StallD upstream.
REQ-010 MemReq  output  1  refill request to the backing instruction memory.
REQ-011 MemA  output  ADDRESS_WIDTH  word-aligned refill address.
REQ-012 MemRD  input  DATA_WIDTH  refill data beat.
REQ-013 MemValid  input  1  MemRD is valid this cycle; one beat is accepted per high cycle.

Function
REQ-014 Line size SHALL be 4 words (16 bytes).
- Offset: A[3:2].
- Index: A[3+log2(SETS):4].
- Tag: the remaining upper bits.
- A[1:0] ignored.
REQ-015 Per-line state SHALL be: valid bit, tag, 4 data words.
REQ-016 hit SHALL be valid[index] AND stored tag equal to tag of A, evaluated combinationally.
REQ-017 FSM SHALL have exactly two states, IDLE and REFILL.
REQ-018 In IDLE with hit, the block SHALL drive RD = word[offset] combinationally and StallI=0 (zero-cycle latency).
REQ-019 In IDLE with miss:
- StallI=1, RD=0.
- Tag and index of A latched.
- Beat counter cleared to 0.
- Next state REFILL.
REQ-020 In REFILL:
- MemReq=1, StallI=1, RD=0.
- MemA = {latched tag, latched index, beat[1:0], 2'b00}.
REQ-021 Each MemValid cycle in REFILL SHALL write MemRD into word[beat] of the latched line and increment beat.
REQ-022 MemA SHALL hold stable between beats while MemValid=0; wait states are unbounded.
REQ-023 On the MemValid of beat 3, the block SHALL set valid and tag of the line and return to IDLE.
- Next cycle is a hit if A still maps to that line.
- Miss penalty is 1 + 4 + memory wait cycles.
REQ-024 The line's valid bit SHALL be cleared on entry to REFILL, so a partially filled line never hits.
REQ-025 A change of A during REFILL (branch redirect, FlushD) SHALL NOT abort the refill; the new A is looked up in IDLE after completion.
REQ-026 MemValid outside REFILL SHALL be ignored and leave all state unchanged.
REQ-027 When not in REFILL, MemReq=0 and MemA=0.
REQ-028 A miss that maps to an already valid index SHALL overwrite (evict) that line; there is no dirty state.

Reset
REQ-029 While RST=1 at a rising edge:
- All valid bits cleared.
- FSM to IDLE, beat=0.
- Counters (if present) to 0.
REQ-030 While RST=1, outputs SHALL be StallI=1, RD=0, MemReq=0, MemA=0.
REQ-031 Reset asserted mid-refill SHALL abandon the refill; the line is left invalid and later MemValid beats are ignored.

Configuration
REQ-032 Macro ICACHE_PERF_EN SHALL control performance counters.
- Defined: adds outputs HitCount and MissCount, each 32-bit.
- HitCount increments on each IDLE cycle with hit and RST=0.
- MissCount increments on each IDLE-to-REFILL transition.
- Both saturate at 0xFFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Verification
REQ-033 Reset, then A=0x00000000 with memory returning 0xA0,0xA1,0xA2,0xA3 at zero wait:
- StallI high for 5 cycles.
- MemA sequence 0x0,0x4,0x8,0xC.
- Then RD=0xA0 with StallI=0.
REQ-034 After REQ-033, A=0x8 -> RD=0xA2 with StallI=0 in the same cycle, and MemReq stays 0.
REQ-035 Refill of A=0x100 with 3 wait cycles before each beat:
- MemA holds each address until MemValid.
- StallI=1 for 17 cycles.
REQ-036 A=0x100 cached (SETS=16), then A=0x200 (same index, different tag):
- Miss and refill occur.
- Subsequent A=0x100 misses again (eviction).
REQ-037 Reset asserted after beat 1 of a refill of 0x40, then stray MemValid pulses:
- Outputs at reset values.
- Subsequent A=0x40 misses and refills all 4 beats.
REQ-038 With ICACHE_PERF_EN defined, sequence REQ-033 then REQ-034 -> MissCount=1, HitCount=2 (fill-complete return cycle plus the 0x8 lookup).

Source files
------------

// File: rtl/icache_if.sv
// ---------------------------------------------------------------------------
// icache_if -- fetch-side and refill-side signal bundle for the icache.
//
// Signals
//   A         fetch byte address from the pipeline (PCF)
//   RD        instruction returned for A, meaningful only when StallI is low
//   StallI    cache cannot deliver RD this cycle
//   MemReq    refill request towards the backing instruction memory
//   MemA      word-aligned refill address
//   MemRD     refill data beat from memory
//   MemValid  MemRD carries a beat this cycle
//
// Modports
//   slave   the cache itself (consumes A / memory beats, produces RD etc.)
//   master  whoever drives the fetch address and models the memory
// ---------------------------------------------------------------------------
interface icache_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
);
   logic [ADDRESS_WIDTH-1:0] A;
   logic [DATA_WIDTH-1:0]    RD;
   logic                     StallI;
   logic                     MemReq;
   logic [ADDRESS_WIDTH-1:0] MemA;
   logic [DATA_WIDTH-1:0]    MemRD;
   logic                     MemValid;

   modport slave (
      input  A, MemRD, MemValid,
      output RD, StallI, MemReq, MemA
   );

   modport master (
      output A, MemRD, MemValid,
      input  RD, StallI, MemReq, MemA
   );
endinterface

// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache -- direct-mapped instruction cache, 4-word lines, blocking refill.
//
// Ports
//   CLK        rising-edge clock
//   RST        synchronous reset, active high
//   bus        icache_if.slave: A/RD/StallI towards the fetch stage,
//              MemReq/MemA/MemRD/MemValid towards instruction memory
//   HitCount   (only with ICACHE_PERF_EN) saturating count of hit cycles
//   MissCount  (only with ICACHE_PERF_EN) saturating count of refills started
//
// Address split: A[3:2] word offset, A[3+log2(SETS):4] index, rest is tag.
// A hit returns the word in the same cycle. A miss stalls, fetches the four
// words of the line in order and then goes back to looking up A.
//
// Optional feature macro: ICACHE_PERF_EN (performance counters).
// ---------------------------------------------------------------------------
module icache #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int SETS          = 16
) (
   input  logic        CLK,
   input  logic        RST,
   icache_if.slave     bus
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0] HitCount,
   output logic [31:0] MissCount
`endif
);

   localparam int INDEX_BITS = $clog2(SETS);
   localparam int TAG_BITS   = ADDRESS_WIDTH - 4 - INDEX_BITS;

   typedef enum logic {IDLE, REFILL} cacheState;

   cacheState                state;
   cacheState                nextState;

   logic [SETS-1:0]          lineValid;
   logic [TAG_BITS-1:0]      lineTag  [SETS];
   logic [DATA_WIDTH-1:0]    lineData [SETS][4];

   logic [TAG_BITS-1:0]      fillTag;
   logic [INDEX_BITS-1:0]    fillIndex;
   logic [1:0]               beat;

   logic [1:0]               reqOffset;
   logic [INDEX_BITS-1:0]    reqIndex;
   logic [TAG_BITS-1:0]      reqTag;
   logic                     hit;
   logic [1:0]               unusedByteBits;

   // Split the fetch address into line fields; byte-within-word bits are
   // irrelevant for a word-wide instruction fetch.
   assign reqOffset      = bus.A[3:2];
   assign reqIndex       = bus.A[3+INDEX_BITS:4];
   assign reqTag         = bus.A[ADDRESS_WIDTH-1:4+INDEX_BITS];
   assign unusedByteBits = bus.A[1:0];

   // The valid bit of a line is dropped as soon as its refill starts, so a
   // half-written line can never produce a hit.
   assign hit = lineValid[reqIndex] && (lineTag[reqIndex] == reqTag);

   // State register. Reset abandons any refill in flight and invalidates
   // every line; the refill bookkeeping is only loaded on a miss.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         lineValid <= '0;
         beat      <= 2'd0;
      end else begin
         state <= nextState;
         case (state)
            IDLE: begin
               if (!hit) begin
                  fillTag             <= reqTag;
                  fillIndex           <= reqIndex;
                  beat                <= 2'd0;
                  lineValid[reqIndex] <= 1'b0;
               end
            end
            REFILL: begin
               if (bus.MemValid) begin
                  lineData[fillIndex][beat] <= bus.MemRD;
                  beat                      <= beat + 2'd1;
                  if (beat == 2'd3) begin
                     lineValid[fillIndex] <= 1'b1;
                     lineTag[fillIndex]   <= fillTag;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state and output decode. Outputs default to the "not ready" view
   // (stalled, no data, no request), which is also what reset shows.
   always_comb begin
      nextState  = state;
      bus.RD     = '0;
      bus.StallI = 1'b1;
      bus.MemReq = 1'b0;
      bus.MemA   = '0;
      if (RST) begin
         nextState = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (hit) begin
                  bus.RD     = lineData[reqIndex][reqOffset];
                  bus.StallI = 1'b0;
               end else begin
                  nextState = REFILL;
               end
            end
            REFILL: begin
               bus.MemReq = 1'b1;
               bus.MemA   = {fillTag, fillIndex, beat, 2'b00};
               if (bus.MemValid && (beat == 2'd3)) begin
                  nextState = IDLE;
               end
            end
            default: nextState = IDLE;
         endcase
      end
   end

`ifdef ICACHE_PERF_EN
   // Saturating performance counters: hits are counted per delivering
   // cycle, misses once per refill started.
   always_ff @(posedge CLK) begin
      if (RST) begin
         HitCount  <= 32'd0;
         MissCount <= 32'd0;
      end else if (state == IDLE) begin
         if (hit) begin
            if (HitCount != 32'hFFFF_FFFF) begin
               HitCount <= HitCount + 32'd1;
            end
         end else begin
            if (MissCount != 32'hFFFF_FFFF) begin
               MissCount <= MissCount + 32'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache.sv
// ---------------------------------------------------------------------------
// tb_icache -- self-checking bench for icache.
//
// The reference keeps, per set, which 16-byte line address is resident;
// instruction memory is a pure function of the word address, so the
// expected instruction for any hit is simply memWord(A). A refill is
// modelled as "line L pending, n beats received".
// Build with ICACHE_PERF_EN defined to also check the counters.
// ---------------------------------------------------------------------------
module tb_icache;

   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int SETS = 16;

   logic CLK;
   logic RST;

   icache_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

`ifdef ICACHE_PERF_EN
   logic [31:0] HitCount;
   logic [31:0] MissCount;
`endif

   icache #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .SETS(SETS)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
`ifdef ICACHE_PERF_EN
      ,
      .HitCount  (HitCount),
      .MissCount (MissCount)
`endif
   );

   // Free-running clock, 10 time units per period.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checksTotal  = 0;
   int checksPassed = 0;

   // Reference model state.
   logic        mLineValid [SETS];
   logic [31:0] mLineAddr  [SETS];
   logic        mRefilling;
   logic [31:0] mPendLine;
   int          mBeats;
   logic [31:0] mHits;
   logic [31:0] mMisses;

   // Every comparison in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checksTotal++;
      if (observed === expected) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Backing memory contents: distinct per word, 0xA0.. from address 0.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return 32'hA0 + (addr >> 2);
   endfunction

   function automatic int setOf(input logic [31:0] addr);
      return int'((addr >> 4) % SETS);
   endfunction

   function automatic logic [31:0] lineOf(input logic [31:0] addr);
      return addr & ~32'hF;
   endfunction

   // One clock cycle: drive inputs on the falling edge, compare outputs
   // against the model just after, then advance the model with the rising
   // edge using the same inputs.
   task automatic applyStimulus(input logic rst, input logic [31:0] addr,
                                input logic mv, output logic stalled);
      logic        expHit;
      logic [31:0] expMemA;
      logic [31:0] expRd;
      logic        expStall;
      logic        expReq;
      int          s;

      @(negedge CLK);
      RST          = rst;
      bus.A        = addr;
      bus.MemValid = mv;
      expMemA      = mPendLine + 32'(4 * mBeats);
      bus.MemRD    = (mRefilling && !rst) ? memWord(expMemA) : $urandom;

      s      = setOf(addr);
      expHit = mLineValid[s] && (mLineAddr[s] == lineOf(addr));

      if (rst) begin
         expStall = 1'b1; expRd = 32'd0; expReq = 1'b0; expMemA = 32'd0;
      end else if (mRefilling) begin
         expStall = 1'b1; expRd = 32'd0; expReq = 1'b1;
      end else begin
         expStall = !expHit;
         expRd    = expHit ? memWord(addr & ~32'h3) : 32'd0;
         expReq   = 1'b0;
         expMemA  = 32'd0;
      end

      #1;
      checkOutput("StallI", 32'(bus.StallI), 32'(expStall));
      checkOutput("RD",     bus.RD,          expRd);
      checkOutput("MemReq", 32'(bus.MemReq), 32'(expReq));
      checkOutput("MemA",   bus.MemA,        expMemA);
`ifdef ICACHE_PERF_EN
      checkOutput("HitCount",  HitCount,  mHits);
      checkOutput("MissCount", MissCount, mMisses);
`endif
      stalled = bus.StallI;

      @(posedge CLK);
      if (rst) begin
         for (int i = 0; i < SETS; i++) mLineValid[i] = 1'b0;
         mRefilling = 1'b0;
         mBeats     = 0;
         mHits      = 32'd0;
         mMisses    = 32'd0;
      end else if (mRefilling) begin
         if (mv) begin
            mBeats++;
            if (mBeats == 4) begin
               mLineValid[setOf(mPendLine)] = 1'b1;
               mLineAddr[setOf(mPendLine)]  = mPendLine;
               mRefilling = 1'b0;
            end
         end
      end else if (expHit) begin
         if (mHits != 32'hFFFF_FFFF) mHits = mHits + 32'd1;
      end else begin
         mRefilling    = 1'b1;
         mPendLine     = lineOf(addr);
         mBeats        = 0;
         mLineValid[s] = 1'b0;
         if (mMisses != 32'hFFFF_FFFF) mMisses = mMisses + 32'd1;
      end
   endtask

   // Hold A until the cache delivers, with a fixed number of memory wait
   // cycles before every beat, then check the length of the stall run.
   task automatic runFetch(input logic [31:0] addr, input int waits,
                           input int expRun);
      int   run;
      int   waitCnt;
      logic mv;
      logic stalled;
      run     = 0;
      waitCnt = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (mRefilling) begin
            mv      = (waitCnt == waits);
            waitCnt = mv ? 0 : waitCnt + 1;
         end else begin
            mv      = 1'b0;
            waitCnt = 0;
         end
         applyStimulus(1'b0, addr, mv, stalled);
         if (!stalled) break;
         run++;
      end
      checkOutput("stallRun", 32'(run), 32'(expRun));
   endtask

   logic        stalledDummy;
   logic [31:0] curA;
   logic        rndMv;
   logic        rndRst;

   initial begin
      RST          = 1'b1;
      bus.A        = '0;
      bus.MemRD    = '0;
      bus.MemValid = 1'b0;
      mRefilling   = 1'b0;
      mPendLine    = 32'd0;
      mBeats       = 0;
      mHits        = 32'd0;
      mMisses      = 32'd0;
      for (int i = 0; i < SETS; i++) begin
         mLineValid[i] = 1'b0;
         mLineAddr[i]  = 32'd0;
      end

      // Reset, then a cold fetch at zero wait and a same-line hit.
      applyStimulus(1'b1, 32'h0, 1'b0, stalledDummy);
      applyStimulus(1'b1, 32'h0, 1'b1, stalledDummy);
      runFetch(32'h0, 0, 5);
      runFetch(32'h8, 0, 0);
`ifdef ICACHE_PERF_EN
      @(negedge CLK);
      #1;
      checkOutput("perfMiss", MissCount, 32'd1);
      checkOutput("perfHit",  HitCount,  32'd2);
`endif

      // Slow memory, then eviction by a conflicting line.
      runFetch(32'h100, 3, 17);
      runFetch(32'h104, 0, 0);
      runFetch(32'h200, 1, 9);
      runFetch(32'h10C, 0, 5);

      // A stray beat while idle must not disturb a resident line.
      applyStimulus(1'b0, 32'h100, 1'b1, stalledDummy);
      runFetch(32'h108, 0, 0);

      // Reset in the middle of a refill, stray beats during reset.
      applyStimulus(1'b0, 32'h40, 1'b0, stalledDummy);
      applyStimulus(1'b0, 32'h40, 1'b1, stalledDummy);
      applyStimulus(1'b0, 32'h40, 1'b1, stalledDummy);
      applyStimulus(1'b1, 32'h40, 1'b0, stalledDummy);
      applyStimulus(1'b1, 32'h40, 1'b1, stalledDummy);
      applyStimulus(1'b1, 32'h40, 1'b1, stalledDummy);
      runFetch(32'h40, 0, 5);
      runFetch(32'h0, 0, 5);

      // Redirect during a refill: the refill runs to completion.
      applyStimulus(1'b0, 32'h3F0, 1'b0, stalledDummy);
      applyStimulus(1'b0, 32'h5A4, 1'b1, stalledDummy);
      applyStimulus(1'b0, 32'h5A4, 1'b0, stalledDummy);
      runFetch(32'h5A4, 0, 8);
      runFetch(32'h3F4, 0, 0);

      // Randomised traffic over a small address pool to force hits,
      // conflicts, redirects, wait states, stray beats and resets.
      curA = 32'h0;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 9) < 3) begin
            curA = (32'($urandom_range(0, 3)) << 8) |
                   (32'($urandom_range(0, 15)) << 4) |
                   32'($urandom_range(0, 15));
         end
         rndRst = ($urandom_range(0, 199) == 0);
         if (mRefilling) rndMv = ($urandom_range(0, 2) != 0);
         else            rndMv = ($urandom_range(0, 7) == 0);
         applyStimulus(rndRst, curA, rndMv, stalledDummy);
      end

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
